dmem_access_arbiter: RTL and testbench

- Sequences and shares the byte-lane data memory between two requesters: the CPU load/store port (port 0) and the debug/loader port (port 1).
- Arbitrates round-robin, latches the winning request and drives the memory's address, data, DataType and write/read strobes in a fixed phase sequence.
- Captures read data and returns a one-cycle ack to the winner.
- Sits between the core and the data memory. The memory's write_clock/read_clock are driven from mem_wr/mem_rd gated by clock at top level.

---
 rtl/dmem_access_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_access_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sequencing two requesters onto the byte-lane data memory.
// Optional misalignment rejection is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH+1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [1:0]            dtype0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH+1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            dtype1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH+1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [1:0]            mem_dtype,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  cur_we;
  logic                  pick;
  logic                  sel_we;
  logic [ADDR_WIDTH+1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_dtype;
  logic                  sel_rej;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  assign sel_we    = pick ? we1    : we0;
  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign sel_dtype = pick ? dtype1 : dtype0;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic cur_rej;

  // Bytes are always aligned; halfwords may not straddle the word boundary.
  always_comb begin
    sel_rej = 1'b0;
    case (sel_dtype)
      2'b01:   sel_rej = 1'b0;
      2'b10:   sel_rej = (sel_addr[1:0] == 2'b11);
      default: sel_rej = (sel_addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_rej <= 1'b0;
    end else if (state == IDLE && (req0 || req1)) begin
      cur_rej <= sel_rej;
    end
  end

  assign err = (state == RESP) && cur_rej;
`else
  assign sel_rej = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_dtype  <= 2'b00;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_grant <= pick;
            cur_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_data   <= sel_wdata;
            mem_dtype  <= sel_dtype;
            state      <= sel_rej ? RESP : ISSUE;
          end
        end
        ISSUE:   state <= cur_we ? RESP : WAIT;
        WAIT: begin
          rdata <= mem_rdata;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // last_grant doubles as the owner of the access in flight.
  assign busy   = (state != IDLE);
  assign ack0   = (state == RESP) && !last_grant;
  assign ack1   = (state == RESP) && last_grant;
  assign mem_wr = (state == ISSUE) && cur_we;
  assign mem_rd = ((state == ISSUE) && !cur_we) || (state == WAIT);

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter with a randomized two-port stimulus.
// Expected err follows DMEM_ARB_ALIGN_CHK_EN the same way as the design build.
module tb_dmem_access_arbiter;

  typedef struct {
    bit          port;
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  dtype;
    logic [31:0] rdata;
    bit          rej;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  dtype0 = '0, dtype1 = '0;
  logic        ack0, ack1, busy, err, mem_wr, mem_rd;
  logic [31:0] rdata, mem_data, mem_rdata;
  logic [5:0]  mem_addr;
  logic [1:0]  mem_dtype;

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];
  exp_t        exp_q [$];
  exp_t        mon_e;
  bit          lg_m = 1'b1;
  logic [31:0] last_rd_m = '0;
  int          checks = 0, passes = 0, fails = 0;
  int          cyc = 0, rise_cyc = 0, strobe_cnt = 0;
  bit          prev_busy = 1'b0;

  dmem_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .dtype0(dtype0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .dtype1(dtype1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_dtype(mem_dtype),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 + i;
  endfunction

  // Simple word store indexed by byte address standing in for the real memory.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_val(i);
    end else if (mem_wr) begin
      env_mem[mem_addr] <= mem_data;
    end
  end
  assign mem_rdata = env_mem[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] dt, input logic [5:0] a);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    if (dt == 2'b01) return 1'b0;
    if (dt == 2'b10) return (a[1:0] == 2'b11);
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one completed access in service order.
  task automatic push_exp(input bit p, input bit w, input logic [5:0] a,
                          input logic [31:0] d, input logic [1:0] t);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = d; e.dtype = t;
    e.rej = misaligned(t, a);
    if (!e.rej) begin
      if (w) ref_mem[a] = d;
      else   last_rd_m = ref_mem[a];
    end
    e.rdata = last_rd_m;
    lg_m = p;
    exp_q.push_back(e);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_mem_dtype"}, mem_dtype, 0);
  endtask

  // Monitor: strobes are checked against the head entry, acks pop it.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      strobe_cnt = 0;
      prev_busy  = 1'b0;
    end else begin
      if (busy && !prev_busy) rise_cyc = cyc;
      prev_busy = busy;
      if (mem_wr || mem_rd) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", {mem_wr, mem_rd}, 2'b00);
        end else begin
          mon_e = exp_q[0];
          check("strobe_wr", mem_wr, mon_e.we);
          check("strobe_rd", mem_rd, !mon_e.we);
          check("strobe_addr", mem_addr, mon_e.addr);
          check("strobe_data", mem_data, mon_e.wdata);
          check("strobe_dtype", mem_dtype, mon_e.dtype);
        end
      end
      if (ack0 || ack1) begin
        check("ack_overlap", ack0 & ack1, 0);
        if (exp_q.size() == 0) begin
          check("ack_unexpected", {ack0, ack1}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_port", ack1, mon_e.port);
          check("ack_err", err, mon_e.rej);
          check("ack_rdata", rdata, mon_e.rdata);
          check("ack_latency", cyc - rise_cyc, mon_e.rej ? 0 : (mon_e.we ? 1 : 2));
          check("ack_strobe_cycles", strobe_cnt, mon_e.rej ? 0 : (mon_e.we ? 1 : 2));
        end
        strobe_cnt = 0;
      end else if (err) begin
        check("err_without_ack", err, 0);
      end
    end
  end

  // One round: the chosen ports request together and each holds until its ack.
  task automatic do_round(input bit m0, input bit m1,
                          input bit w0, input logic [5:0] a0, input logic [31:0] d0, input logic [1:0] t0,
                          input bit w1, input logic [5:0] a1, input logic [31:0] d1, input logic [1:0] t1);
    bit first, done0, done1;
    int gap, n;
    first = (m0 && m1) ? ~lg_m : m1;
    if (!first) push_exp(1'b0, w0, a0, d0, t0);
    else        push_exp(1'b1, w1, a1, d1, t1);
    if (m0 && m1) begin
      if (first) push_exp(1'b0, w0, a0, d0, t0);
      else       push_exp(1'b1, w1, a1, d1, t1);
    end
    we0 = w0; addr0 = a0; wdata0 = d0; dtype0 = t0; req0 = m0;
    we1 = w1; addr1 = a1; wdata1 = d1; dtype1 = t1; req1 = m1;
    done0 = !m0; done1 = !m1; gap = 0; n = 0;
    while (!(done0 && done1) && n < 40) begin
      @(negedge clock);
      n++;
      if (m0 && m1 && (done0 ^ done1) && !busy) gap++;
      if (!done0 && ack0) begin req0 = 1'b0; done0 = 1'b1; end
      if (!done1 && ack1) begin req1 = 1'b0; done1 = 1'b1; end
    end
    check("round_done", {done0, done1}, 2'b11);
    if (!(done0 && done1)) begin
      req0 = 1'b0; req1 = 1'b0;
      exp_q.delete();
    end else if (m0 && m1) begin
      check("rr_busy_gap", gap, 1);
    end
  endtask

  task automatic applyStimulus(input int rounds);
    bit m0, m1;
    int mask;
    for (int r = 0; r < rounds; r++) begin
      mask = $urandom_range(1, 3);
      m0 = mask[0]; m1 = mask[1];
      do_round(m0, m1,
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  // Reset lands in WAIT of a port 1 read: no ack, everything back to reset values.
  task automatic abort_in_wait();
    exp_t e;
    e.port = 1'b1; e.we = 1'b0; e.addr = 6'h08; e.wdata = 32'h1234_5678;
    e.dtype = 2'b00; e.rdata = '0; e.rej = 1'b0;
    exp_q.push_back(e);
    we1 = 1'b0; addr1 = 6'h08; wdata1 = 32'h1234_5678; dtype1 = 2'b00; req1 = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("abort_wait_rd", mem_rd, 1);
    #2 reset = 1'b1;
    req1 = 1'b0;
    #1 reset_checks("abort");
    exp_q.delete();
    lg_m = 1'b1;
    last_rd_m = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clock);
    reset_checks("reset");
    #2 reset = 1'b0;
    do_round(1, 0, 1, 6'h04, 32'hDEADBEEF, 2'b00, 0, 6'h00, 32'h0, 2'b00);
    do_round(1, 0, 0, 6'h04, 32'h0, 2'b00, 0, 6'h00, 32'h0, 2'b00);
    do_round(0, 1, 0, 6'h00, 32'h0, 2'b00, 0, 6'h07, 32'h0, 2'b01);
    do_round(1, 1, 1, 6'h10, 32'h1111_0000, 2'b00, 1, 6'h14, 32'h2222_0000, 2'b00);
    do_round(1, 1, 0, 6'h14, 32'h0, 2'b00, 0, 6'h10, 32'h0, 2'b00);
    do_round(1, 0, 1, 6'h02, 32'hCAFEF00D, 2'b00, 0, 6'h00, 32'h0, 2'b00);
    do_round(1, 0, 0, 6'h02, 32'h0, 2'b10, 0, 6'h00, 32'h0, 2'b00);
    applyStimulus(80);
    repeat (2) @(negedge clock);
    abort_in_wait();
    do_round(1, 1, 0, 6'h08, 32'h0, 2'b00, 1, 6'h0C, 32'h5A5A_A5A5, 2'b00);
    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
